// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin owner of a single-ported memory among four requesters;
// a grant is held until done or timeout and drives the select of the port muxes.
module mem_port_arbiter #(
   parameter int n       = 32,
   parameter int TIMEOUT = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] req_i,
   input  logic       done_i,
   output logic [3:0] gnt_o,
   output logic [1:0] sel_o,
   output logic       busy_o,
   output logic       err_o
);
   localparam int CW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
   localparam logic [CW-1:0] LIM = TIMEOUT > 0 ? CW'(TIMEOUT - 1) : '1;

   typedef enum logic {IDLE, BUSY} state_t;

   state_t        state_q, state_d;
   logic [1:0]    ptr_q, ptr_d, sel_q, sel_d, nxt, win;
   logic [3:0]    gnt_q, gnt_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          err_q, err_d, expire;

   // the arbiter carries no data; n only sizes the muxes it steers
   if (n < 1) begin : g_bad_width
   end

   // first requester at or after p in circular order
   function automatic logic [1:0] pick(input logic [3:0] r, input logic [1:0] p);
      pick = p;
      for (int k = 3; k >= 0; k--)
         if (r[p + 2'(k)]) pick = p + 2'(k);
   endfunction

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      gnt_d   = gnt_q;
      sel_d   = sel_q;
      err_d   = 1'b0;
      cnt_d   = (state_q == BUSY && cnt_q != LIM) ? cnt_q + 1'b1 : cnt_q;
      expire  = (TIMEOUT != 0) && (cnt_q == LIM);
      nxt     = sel_q + 2'd1;
      win     = pick(req_i, state_q == BUSY ? nxt : ptr_q);
      if (state_q == BUSY && (done_i || expire)) begin
         state_d = IDLE;
         ptr_d   = nxt;
         gnt_d   = '0;
         err_d   = !done_i;
      end
      // a timeout closes without re-arbitrating; done hands over with no bubble
      if ((state_q == IDLE || done_i) && |req_i) begin
         state_d = BUSY;
         gnt_d   = 4'b1 << win;
         sel_d   = win;
         cnt_d   = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         gnt_q   <= '0;
         sel_q   <= '0;
         cnt_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         gnt_q   <= gnt_d;
         sel_q   <= sel_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
      end

   assign gnt_o  = gnt_q;
   assign sel_o  = sel_q;
   assign busy_o = state_q == BUSY;
   assign err_o  = err_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scenarios plus randomized traffic checked against
// an edge-counting reference model of the arbitration rules.
module tb_mem_port_arbiter;
   localparam int TO = 16;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic [3:0] req = '0;
   logic       done = 1'b0;
   logic [3:0] gnt;
   logic [1:0] sel;
   logic       busy, err;
   int         tests = 0, fails = 0;

   mem_port_arbiter #(.n(32), .TIMEOUT(TO)) dut (
      .clk(clk), .rst_n(rst_n), .req_i(req), .done_i(done),
      .gnt_o(gnt), .sel_o(sel), .busy_o(busy), .err_o(err)
   );

   always #5 clk = ~clk;

   // reference model: owner, pointer and the edge index at which the grant was issued
   bit m_busy, m_err;
   int m_own, m_ptr, m_edge, m_gedge;

   function automatic int first(input logic [3:0] r, input int p);
      for (int o = 0; o < 4; o++)
         if (r[(p + o) % 4]) return (p + o) % 4;
      return 0;
   endfunction

   always @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         m_busy <= 0; m_err <= 0; m_own <= 0; m_ptr <= 0; m_edge <= 0; m_gedge <= 0;
      end else begin
         m_edge <= m_edge + 1;
         m_err  <= 0;
         if (!m_busy) begin
            if (req != 0) begin
               m_busy <= 1; m_own <= first(req, m_ptr); m_gedge <= m_edge + 1;
            end
         end else if (done) begin
            m_ptr <= (m_own + 1) % 4;
            if (req != 0) begin
               m_own <= first(req, (m_own + 1) % 4); m_gedge <= m_edge + 1;
            end else m_busy <= 0;
         end else if (m_edge + 1 - m_gedge == TO) begin
            m_busy <= 0; m_ptr <= (m_own + 1) % 4; m_err <= 1;
         end
      end

   task automatic drive(input logic [3:0] r, input logic d);
      req = r; done = d;
      @(posedge clk); #1;
   endtask

   task automatic do_reset;
      rst_n = 0; req = 0; done = 0;
      #7 rst_n = 1;
      @(posedge clk); #1;
   endtask

   task automatic test_reset;
      #1 rst_n = 0;
      #1;
      tests += 4;
      if (gnt !== 4'b0000) begin fails++; $display("FAIL reset_gnt: got %b want 0000", gnt); end
      if (sel !== 2'b00) begin fails++; $display("FAIL reset_sel: got %b want 00", sel); end
      if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
      if (err !== 1'b0) begin fails++; $display("FAIL reset_err: got %b want 0", err); end
      @(negedge clk);
      rst_n = 1; req = 4'b1111;
      @(posedge clk); #1;
      tests += 3;
      if (gnt !== 4'b0001) begin fails++; $display("FAIL first_gnt: got %b want 0001", gnt); end
      if (sel !== 2'b00) begin fails++; $display("FAIL first_sel: got %b want 00", sel); end
      if (busy !== 1'b1) begin fails++; $display("FAIL first_busy: got %b want 1", busy); end
      drive(4'b1111, 1'b0);
      #2 rst_n = 0;
      #1;
      tests += 3;
      if (gnt !== 4'b0000) begin fails++; $display("FAIL async_gnt: got %b want 0000", gnt); end
      if (sel !== 2'b00) begin fails++; $display("FAIL async_sel: got %b want 00", sel); end
      if (busy !== 1'b0) begin fails++; $display("FAIL async_busy: got %b want 0", busy); end
      rst_n = 1;
   endtask

   task automatic test_rotation;
      do_reset();
      drive(4'b1111, 1'b0);
      for (int i = 0; i < 5; i++) begin
         tests += 3;
         if (gnt !== 4'(1 << (i % 4))) begin fails++; $display("FAIL rot_gnt[%0d]: got %b want %b", i, gnt, 4'(1 << (i % 4))); end
         if (sel !== 2'(i % 4)) begin fails++; $display("FAIL rot_sel[%0d]: got %0d want %0d", i, sel, i % 4); end
         drive(4'b1111, 1'b0);
         if (busy !== 1'b1) begin fails++; $display("FAIL rot_busy[%0d]: got %b want 1", i, busy); end
         drive(4'b1111, 1'b1);
      end
   endtask

   task automatic test_fairness;
      do_reset();
      drive(4'b0001, 1'b0);
      drive(4'b1001, 1'b1);
      tests += 3;
      if (gnt !== 4'b1000) begin fails++; $display("FAIL skip_gnt: got %b want 1000", gnt); end
      if (sel !== 2'b11) begin fails++; $display("FAIL skip_sel: got %b want 11", sel); end
      drive(4'b1001, 1'b1);
      if (gnt !== 4'b0001) begin fails++; $display("FAIL wrap_gnt: got %b want 0001", gnt); end
   endtask

   task automatic test_hold;
      do_reset();
      drive(4'b0100, 1'b0);
      for (int k = 0; k < 6; k++) begin
         tests++;
         if (gnt !== 4'b0100) begin fails++; $display("FAIL hold_gnt[%0d]: got %b want 0100", k, gnt); end
         if (k < 5) drive(4'b0000, 1'b0);
      end
      drive(4'b0000, 1'b1);
      tests += 3;
      if (gnt !== 4'b0000) begin fails++; $display("FAIL hold_rel: got %b want 0000", gnt); end
      if (busy !== 1'b0) begin fails++; $display("FAIL hold_busy: got %b want 0", busy); end
      if (sel !== 2'b10) begin fails++; $display("FAIL hold_sel: got %b want 10", sel); end
   endtask

   task automatic test_timeout;
      do_reset();
      drive(4'b0010, 1'b0);
      for (int k = 1; k < TO; k++) begin
         drive(4'b0011, 1'b0);
         tests++;
         if (gnt !== 4'b0010 || err !== 1'b0) begin fails++; $display("FAIL to_hold[%0d]: got gnt=%b err=%b want 0010/0", k, gnt, err); end
      end
      drive(4'b0011, 1'b0);
      tests += 3;
      if (gnt !== 4'b0000) begin fails++; $display("FAIL to_gnt: got %b want 0000", gnt); end
      if (err !== 1'b1) begin fails++; $display("FAIL to_err: got %b want 1", err); end
      if (busy !== 1'b0) begin fails++; $display("FAIL to_busy: got %b want 0", busy); end
      drive(4'b0011, 1'b0);
      tests += 2;
      if (err !== 1'b0) begin fails++; $display("FAIL to_err_clear: got %b want 0", err); end
      if (gnt !== 4'b0001) begin fails++; $display("FAIL to_next: got %b want 0001", gnt); end
   endtask

   task automatic test_collision;
      do_reset();
      drive(4'b0100, 1'b0);
      for (int k = 1; k < TO; k++) drive(4'b0100, 1'b0);
      drive(4'b0101, 1'b1);
      tests += 3;
      if (err !== 1'b0) begin fails++; $display("FAIL col_err: got %b want 0", err); end
      if (gnt !== 4'b0001) begin fails++; $display("FAIL col_gnt: got %b want 0001", gnt); end
      if (busy !== 1'b1) begin fails++; $display("FAIL col_busy: got %b want 1", busy); end
      drive(4'b0000, 1'b1);
      drive(4'b0000, 1'b1);
      tests += 2;
      if (gnt !== 4'b0000 || busy !== 1'b0) begin fails++; $display("FAIL idle_done: got gnt=%b busy=%b want 0000/0", gnt, busy); end
      if (sel !== 2'b00 || err !== 1'b0) begin fails++; $display("FAIL idle_done_sel: got sel=%b err=%b want 00/0", sel, err); end
   endtask

   task automatic test_random;
      logic [3:0] eg;
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         drive($urandom_range(3) == 0 ? 4'b0000 : 4'($urandom), $urandom_range(7) == 0);
         eg = m_busy ? 4'(1 << m_own) : 4'b0000;
         tests++;
         if (gnt !== eg || sel !== 2'(m_own) || busy !== m_busy || err !== m_err) begin
            fails++;
            $display("FAIL rand[%0d]: got gnt=%b sel=%0d busy=%b err=%b want %b/%0d/%b/%b",
                     c, gnt, sel, busy, err, eg, m_own, m_busy, m_err);
         end
      end
   endtask

   initial begin
      test_reset();
      test_rotation();
      test_fairness();
      test_hold();
      test_timeout();
      test_collision();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
